// File: rtl/pwm_duty_ramp_ctrl.sv
// rtl/pwm_duty_ramp_ctrl.sv - duty-cycle ramp controller stepping a PWM duty value toward a target
// Optional macro RAMP_BYPASS_EN adds cmd_immediate for a direct duty load without ramping.
module pwm_duty_ramp_ctrl #(
  parameter int DUTY_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_target,
  input  logic [DIV_W-1:0]  cmd_interval,
`ifdef RAMP_BYPASS_EN
  input  logic              cmd_immediate,
`endif
  input  logic              abort,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done,
  output logic              step_tick
);

  typedef enum logic {IDLE, RAMP} state_t;

  localparam logic [DUTY_W-1:0] DUTY_ONE = 1;
  localparam logic [DIV_W-1:0]  DIV_ONE  = 1;

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DIV_W-1:0]  reload_q, reload_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              tick_q, tick_d;
  logic              accept;
  logic              imm;

`ifdef RAMP_BYPASS_EN
  assign imm = cmd_immediate;
`else
  assign imm = 1'b0;
`endif

  // abort blocks an accept even though cmd_ready is still high
  assign accept = cmd_valid && (state_q == IDLE) && !abort;

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    reload_d = reload_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    tick_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (imm) begin
            duty_d = cmd_target;
            tick_d = (cmd_target != duty_q);
            done_d = 1'b1;
          end else if (cmd_target == duty_q) begin
            done_d = 1'b1;
          end else begin
            target_d = cmd_target;
            reload_d = (cmd_interval == '0) ? '0 : cmd_interval - DIV_ONE;
            cnt_d    = (cmd_interval == '0) ? '0 : cmd_interval - DIV_ONE;
            state_d  = RAMP;
          end
        end
      end
      RAMP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          // target bounds every step, so the +/-1 can never wrap
          duty_d = (target_q > duty_q) ? duty_q + DUTY_ONE : duty_q - DUTY_ONE;
          tick_d = 1'b1;
          cnt_d  = reload_q;
          if (duty_d == target_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - DIV_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      target_q <= '0;
      reload_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      tick_q   <= tick_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RAMP);
  assign duty      = duty_q;
  assign done      = done_q;
  assign step_tick = tick_q;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// tb/tb_pwm_duty_ramp_ctrl.sv - self-checking bench for pwm_duty_ramp_ctrl with a schedule-based reference model
module tb_pwm_duty_ramp_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_target;
  logic [15:0] cmd_interval;
  logic        cmd_immediate;
  logic        abort;
  logic [7:0]  duty;
  logic        busy;
  logic        done;
  logic        step_tick;

  always #5 clk = ~clk;

  pwm_duty_ramp_ctrl #(.DUTY_W(8), .DIV_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_target(cmd_target),
    .cmd_interval(cmd_interval),
`ifdef RAMP_BYPASS_EN
    .cmd_immediate(cmd_immediate),
`endif
    .abort(abort),
    .duty(duty),
    .busy(busy),
    .done(done),
    .step_tick(step_tick)
  );

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;
  int done_cnt = 0;

  // Reference: ramp defined by accept edge, start, target, interval; k-th change at edge acc_t + k*iv
  int         t = 0;
  int         acc_t = 0;
  int         m_start = 0;
  int         m_tgt = 0;
  int         m_iv = 1;
  logic       m_busy = 1'b0;
  logic [7:0] m_duty = 8'd0;
  logic       m_done = 1'b0;
  logic       m_tick = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic model_edge();
    int el;
    int k;
    m_done = 1'b0;
    m_tick = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      m_duty = 8'd0;
    end else if (m_busy) begin
      if (abort) begin
        m_busy = 1'b0;
      end else begin
        el = t - acc_t;
        if (el % m_iv == 0) begin
          k = el / m_iv;
          m_duty = (m_tgt > m_start) ? 8'(m_start + k) : 8'(m_start - k);
          m_tick = 1'b1;
          if (int'(m_duty) == m_tgt) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
      end
    end else if (cmd_valid && !abort) begin
`ifdef RAMP_BYPASS_EN
      if (cmd_immediate) begin
        m_tick = (cmd_target != m_duty);
        m_duty = cmd_target;
        m_done = 1'b1;
      end else
`endif
      if (cmd_target == m_duty) begin
        m_done = 1'b1;
      end else begin
        m_busy  = 1'b1;
        acc_t   = t;
        m_start = int'(m_duty);
        m_tgt   = int'(cmd_target);
        m_iv    = (cmd_interval == 16'd0) ? 1 : int'(cmd_interval);
      end
    end
    t++;
  endtask

  task automatic compare();
    chk("duty", int'(duty), int'(m_duty));
    chk("busy", int'(busy), int'(m_busy));
    chk("cmd_ready", int'(cmd_ready), int'(!m_busy));
    chk("done", int'(done), int'(m_done));
    chk("step_tick", int'(step_tick), int'(m_tick));
    tick_cnt += int'(step_tick);
    done_cnt += int'(done);
  endtask

  task automatic cyc(input logic v, input logic [7:0] tg, input logic [15:0] iv,
                     input logic ab, input logic r, input logic im);
    cmd_valid     = v;
    cmd_target    = tg;
    cmd_interval  = iv;
    abort         = ab;
    rst           = r;
    cmd_immediate = im;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    cmd_valid = 0; cmd_target = 0; cmd_interval = 0; abort = 0; rst = 1; cmd_immediate = 0;
    @(negedge clk);
    cyc(1'b0, 8'd0, 16'd0, 1'b0, 1'b1, 1'b0);
    chk("reset_ready", int'(cmd_ready), 1);
    chk("reset_duty", int'(duty), 0);

    // up-ramp 0 -> 5, interval 3
    tick_cnt = 0; done_cnt = 0;
    cyc(1'b1, 8'd5, 16'd3, 1'b0, 1'b0, 1'b0);
    chk("up_busy_after_accept", int'(busy), 1);
    for (int j = 1; j <= 17; j++) begin
      idle(1);
      if (j == 2)  chk("up_duty_j2", int'(duty), 0);
      if (j == 3)  chk("up_duty_j3", int'(duty), 1);
      if (j == 14) chk("up_busy_j14", int'(busy), 1);
      if (j == 15) begin
        chk("up_duty_j15", int'(duty), 5);
        chk("up_done_j15", int'(done), 1);
        chk("up_busy_j15", int'(busy), 0);
      end
      if (j == 16) chk("up_done_j16", int'(done), 0);
    end
    chk("up_ticks", tick_cnt, 5);
    chk("up_dones", done_cnt, 1);

    // down-ramp 5 -> 2, interval 0
    done_cnt = 0;
    cyc(1'b1, 8'd2, 16'd0, 1'b0, 1'b0, 1'b0);
    idle(1); chk("down_j1", int'(duty), 4);
    idle(1); chk("down_j2", int'(duty), 3);
    idle(1); chk("down_j3", int'(duty), 2);
    chk("down_done", int'(done), 1);
    idle(2);
    chk("down_dones", done_cnt, 1);

    // no-op at duty 7
    cyc(1'b1, 8'd7, 16'd1, 1'b0, 1'b0, 1'b0);
    idle(6);
    chk("pre_noop_duty", int'(duty), 7);
    done_cnt = 0;
    cyc(1'b1, 8'd7, 16'd4, 1'b0, 1'b0, 1'b0);
    chk("noop_busy", int'(busy), 0);
    chk("noop_done", int'(done), 1);
    idle(1);
    chk("noop_done_once", int'(done), 0);
    chk("noop_duty", int'(duty), 7);

    // abort during 0 -> 10 ramp
    cyc(1'b0, 8'd0, 16'd0, 1'b0, 1'b1, 1'b0);
    done_cnt = 0;
    cyc(1'b1, 8'd10, 16'd2, 1'b0, 1'b0, 1'b0);
    idle(6);
    chk("abort_pre_duty", int'(duty), 3);
    cyc(1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0);
    chk("abort_duty", int'(duty), 3);
    chk("abort_ready", int'(cmd_ready), 1);
    idle(4);
    chk("abort_hold", int'(duty), 3);
    chk("abort_no_done", done_cnt, 0);
    cyc(1'b1, 8'd9, 16'd1, 1'b1, 1'b0, 1'b0);
    chk("abort_blocks_accept", int'(busy), 0);
    cyc(1'b1, 8'd4, 16'd1, 1'b0, 1'b0, 1'b0);
    chk("abort_new_cmd", int'(busy), 1);
    idle(2);

    // full scale 0 -> 255, interval 1
    cyc(1'b0, 8'd0, 16'd0, 1'b0, 1'b1, 1'b0);
    tick_cnt = 0; done_cnt = 0;
    cyc(1'b1, 8'd255, 16'd1, 1'b0, 1'b0, 1'b0);
    idle(258);
    chk("full_ticks", tick_cnt, 255);
    chk("full_duty", int'(duty), 255);
    chk("full_dones", done_cnt, 1);

    // reset mid-ramp
    cyc(1'b0, 8'd0, 16'd0, 1'b0, 1'b1, 1'b0);
    done_cnt = 0;
    cyc(1'b1, 8'd255, 16'd1, 1'b0, 1'b0, 1'b0);
    idle(100);
    chk("mid_duty", int'(duty), 100);
    cyc(1'b1, 8'd3, 16'd0, 1'b1, 1'b1, 1'b0);
    chk("rst_mid_duty", int'(duty), 0);
    chk("rst_mid_busy", int'(busy), 0);
    idle(2);
    chk("rst_mid_no_done", done_cnt, 0);

`ifdef RAMP_BYPASS_EN
    cyc(1'b1, 8'd200, 16'd5, 1'b0, 1'b0, 1'b1);
    chk("bypass_duty", int'(duty), 200);
    chk("bypass_done", int'(done), 1);
    chk("bypass_busy", int'(busy), 0);
    idle(1);
    chk("bypass_done_once", int'(done), 0);
`endif

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic       v, ab, r, im;
      logic [7:0] tg;
      logic [15:0] iv;
      v  = ($urandom_range(0, 99) < 30);
      ab = ($urandom_range(0, 99) < 3);
      r  = ($urandom_range(0, 999) < 5);
      im = ($urandom_range(0, 99) < 15);
      iv = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) tg = m_duty + 8'($urandom_range(0, 2)) - 8'd1;
      else if ($urandom_range(0, 7) == 0) tg = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
      else tg = 8'($urandom_range(0, 255));
      cyc(v, tg, iv, ab, r, im);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_duty_ramp_ctrl.md
PWM_DUTY_RAMP_CTRL -- requirements
Module: pwm_duty_ramp_ctrl

Interface
REQ-001 Parameter: DUTY_W, default 8, width of the duty value driven to the PWM peripheral.
REQ-002 Parameter: DIV_W, default 16, width of the per-step interval field.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 cmd_valid  input  1  ramp command offered.
REQ-006 cmd_ready  output  1  controller can accept a command.
REQ-007 cmd_target  input  DUTY_W  final duty value of the ramp.
REQ-008 cmd_interval  input  DIV_W  clk cycles per duty step; 0 is treated as 1.
REQ-009 abort  input  1  stop the active ramp and hold the current duty.
REQ-010 duty  output  DUTY_W  registered duty value feeding the PWM peripheral's duty-cycle input.
REQ-011 busy  output  1  ramp in progress.
REQ-012 done  output  1  one-cycle pulse: the ramp completed normally.
REQ-013 step_tick  output  1  one-cycle pulse on every duty change.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and RAMP; busy = (state == RAMP); cmd_ready = (state == IDLE).
REQ-015 A command SHALL be accepted on an edge where cmd_valid && cmd_ready; in RAMP, cmd_valid SHALL be ignored and SHALL NOT be queued.
REQ-016 On accept with cmd_target != duty, the controller SHALL latch the target and I = max(cmd_interval, 1), load the step counter with I-1, and enter RAMP.
REQ-017 On accept with cmd_target == duty, the state SHALL stay IDLE, duty SHALL NOT change, and done SHALL pulse in the following cycle.
REQ-018 In RAMP, the counter SHALL decrement each cycle; when it reads 0, duty SHALL step by exactly 1 toward the target, step_tick SHALL pulse, and the counter SHALL reload I-1.
REQ-019 For an accept at edge N, the k-th duty change SHALL occur at edge N + k*I, for k = 1..|target - start|.
REQ-020 On the edge where duty becomes equal to the target, the state SHALL return to IDLE and done SHALL be high in the cycle that follows.
REQ-021 Duty arithmetic SHALL be unsigned DUTY_W and SHALL never wrap; the target bounds every step, so 0 and 2^DUTY_W-1 are reachable and never overshot.
REQ-022 abort in RAMP SHALL return the FSM to IDLE on that edge, hold duty, suppress any step due on that edge, and SHALL NOT pulse done.
REQ-023 abort in IDLE SHALL have no effect; abort asserted together with an accepting cmd_valid SHALL block the accept.
REQ-024 done and step_tick SHALL be registered and never high for more than one consecutive cycle per event.

Reset
REQ-025 When rst is high at an edge: state SHALL be IDLE, and duty, counter, latched target, done and step_tick SHALL all be 0.
REQ-026 rst SHALL take priority over abort and commands; a reset mid-ramp SHALL drive duty to 0 on that edge with no done pulse.
REQ-027 cmd_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-028 Macro RAMP_BYPASS_EN: when defined, an input port cmd_immediate (1 bit) SHALL exist; an accept with cmd_immediate = 1 SHALL load duty = cmd_target on the accept edge, stay IDLE, pulse step_tick if the value changed, and pulse done in the next cycle.
REQ-029 When RAMP_BYPASS_EN is undefined, the cmd_immediate port SHALL be absent and every command SHALL ramp per REQ-016..REQ-020.

Verification
REQ-030 Up-ramp: after reset, target=5, interval=3, accept at edge N -> duty = 1..5 at edges N+3, N+6, N+9, N+12, N+15; busy high over that window; one done pulse; five step_tick pulses.
REQ-031 Down-ramp: duty=5, target=2, interval=0 -> duty 4, 3, 2 on three consecutive edges; one done pulse.
REQ-032 No-op command: duty=7, target=7 -> busy never rises, duty unchanged, done high for exactly one cycle.
REQ-033 Abort: ramp 0 -> 10 with interval 2, abort at the edge after duty reaches 3 -> duty holds 3, no done, cmd_ready=1 next cycle, a new command is accepted.
REQ-034 Full scale and reset: 0 -> 255 with interval 1 -> 255 step_ticks, duty ends at 255 with no wrap; a repeat run with rst mid-ramp -> duty 0 on that edge, no done.
REQ-035 With RAMP_BYPASS_EN: cmd_immediate=1, target=200 -> duty=200 on the accept edge, done the next cycle, busy stays 0.
